// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with stall (hold), flush (bubble), valid tracking and
// saturating stall/flush event counters for perf/debug.
module id_exe_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = 5,
  parameter int FUNC_W     = 6,
  parameter int ALUOP_W    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  clr_cnt,
  input  logic                  in_valid,
  input  logic [8:0]            in_ctrl,
  input  logic [ALUOP_W-1:0]    in_aluop,
  input  logic [DATA_W-1:0]     in_pcplus4,
  input  logic [DATA_W-1:0]     in_rs_val,
  input  logic [DATA_W-1:0]     in_rt_val,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs_reg,
  input  logic [REG_ADDR_W-1:0] in_rt_reg,
  input  logic [REG_ADDR_W-1:0] in_rd_reg,
  input  logic [SHAMT_W-1:0]    in_shamt,
  input  logic [FUNC_W-1:0]     in_func,
  output logic                  out_valid,
  output logic [8:0]            out_ctrl,
  output logic [ALUOP_W-1:0]    out_aluop,
  output logic [DATA_W-1:0]     out_pcplus4,
  output logic [DATA_W-1:0]     out_rs_val,
  output logic [DATA_W-1:0]     out_rt_val,
  output logic [DATA_W-1:0]     out_imm,
  output logic [REG_ADDR_W-1:0] out_rs_reg,
  output logic [REG_ADDR_W-1:0] out_rt_reg,
  output logic [REG_ADDR_W-1:0] out_rd_reg,
  output logic [SHAMT_W-1:0]    out_shamt,
  output logic [FUNC_W-1:0]     out_func,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_aluop   <= '0;
      out_pcplus4 <= '0;
      out_rs_val  <= '0;
      out_rt_val  <= '0;
      out_imm     <= '0;
      out_rs_reg  <= '0;
      out_rt_reg  <= '0;
      out_rd_reg  <= '0;
      out_shamt   <= '0;
      out_func    <= '0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      // Control is gated by valid so a non-valid slot can never write, access memory or branch.
      out_ctrl    <= in_valid ? in_ctrl  : '0;
      out_aluop   <= in_valid ? in_aluop : '0;
      out_pcplus4 <= in_pcplus4;
      out_rs_val  <= in_rs_val;
      out_rt_val  <= in_rt_val;
      out_imm     <= in_imm;
      out_rs_reg  <= in_rs_reg;
      out_rt_reg  <= in_rt_reg;
      out_rd_reg  <= in_rd_reg;
      out_shamt   <= in_shamt;
      out_func    <= in_func;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // A flush wins over a simultaneous stall, so only one of the two counts per cycle.
      if (stall && !flush && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule
